wb_tcm: RTL and testbench
=========================

# wb_tcm

Wishbone-slave tightly-coupled memory filling main-NIC slot 0 (address window 0x0xxx_xxxx), the responder side of the core's Wishbone data port. It accepts single read/write cycles from the core through the NIC device-select, stores 32-bit words with byte-lane writes, and answers each access with one registered ACK pulse after a programmable number of wait states. Its read data and ACK feed the NIC slave read-data and ACK vectors at index 0.

## Interface
- DEPTH_LOG2, 12: memory holds 2^DEPTH_LOG2 32-bit words.
- WAIT_STATES, 0: extra cycles between request acceptance and ACK; legal range 0..15.
- INIT_FILE, "": when non-empty, memory is preloaded with $readmemh at elaboration.

- i_clk  in  1  core clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_dev_sel  in  1  NIC slot select, window decoded from address [31:28].
- i_wb_adr  in  DEPTH_LOG2  word address, byte address [DEPTH_LOG2+1:2].
- i_wb_dat  in  32  write data.
- i_wb_sel  in  4  byte-lane enables; bit n enables byte [8n+7:8n].
- i_wb_we  in  1  1 = write, 0 = read.
- i_wb_stb  in  1  strobe.
- i_wb_cyc  in  1  bus cycle valid.
- o_wb_dat  out  32  registered read data.
- o_wb_ack  out  1  one-cycle acknowledge.

## Operation
- Request = i_dev_sel & i_wb_cyc & i_wb_stb.
- FSM states: IDLE, WAIT, ACK.
- IDLE: on a request, latch adr/dat/sel/we. If WAIT_STATES=0, go to ACK; otherwise load the wait counter with WAIT_STATES-1 and go to WAIT.
- WAIT: decrement the counter each cycle. When the counter is 0, go to ACK. If i_wb_cyc is low in any WAIT cycle, abort: go to IDLE, no write, no ACK.
- ACK: o_wb_ack=1 for exactly this cycle, then go to IDLE unconditionally.
- Write commit: on the edge entering ACK, each byte with latched sel[n]=1 is written to mem[latched adr]. sel=4'b0000 still ACKs and leaves memory unchanged.
- Read: on the edge entering ACK, o_wb_dat loads the full word mem[latched adr]. sel is ignored for reads. o_wb_dat holds its value until the next read enters ACK; writes do not alter it.
- Address wraps modulo 2^DEPTH_LOG2. There are no error responses.
- Memory contents are not affected by reset.

## Timing
- Reset values: o_wb_ack=0, o_wb_dat=0, FSM=IDLE, counter=0, latched request fields=0.
- Latency: request sampled in IDLE at edge N → o_wb_ack high during cycle N+1+WAIT_STATES.
- ACK is registered. There is no combinational path from any input to o_wb_ack or o_wb_dat.
- Back-to-back: a request held after ACK is re-sampled in the IDLE cycle following ACK. Minimum repeat period is 2+WAIT_STATES cycles.
- Request fields are sampled only in IDLE. Changes to inputs during WAIT or ACK are ignored, except i_wb_cyc for abort.
- i_wb_cyc dropping during the ACK cycle has no effect: the write is already committed and the ACK is still driven.
- Reset asserted mid-transaction: immediate return to IDLE and ack=0. A write not yet committed is dropped.
- i_dev_sel low in IDLE: no request is accepted, even with cyc and stb high.

## Test plan
- Reset, then WAIT_STATES=0: write 0xDEADBEEF to word 5, sel=4'hF, then read word 5 → ACK one cycle after each request; read returns 0xDEADBEEF; o_wb_dat=0 before the first read.
- Byte lanes: word 7 = 0x11223344; write 0xAABBCCDD with sel=4'b0101 → read returns 0x11BB33DD. Write with sel=0 → ACK asserted, word unchanged.
- WAIT_STATES=3: hold a read request → ACK exactly 4 cycles after the sampling edge, high for 1 cycle. A held request is re-accepted in the following IDLE cycle, giving a 5-cycle period.
- Abort: WAIT_STATES=3, issue a write, drop i_wb_cyc in the second WAIT cycle → no ACK, memory unchanged, FSM back in IDLE.
- Address wrap: DEPTH_LOG2=4, write 0x12345678 to address 0x13 → a read of address 0x3 returns 0x12345678.
- Async reset asserted during WAIT of a write → o_wb_ack=0 immediately, target word unchanged, next request serviced with normal latency.

Source files
------------

// File: rtl/wb_tcm.sv
// Wishbone-slave tightly-coupled memory: single-cycle-request responder with
// byte-lane writes, registered read data and a programmable wait-state ACK.
module wb_tcm #(
    parameter int    DEPTH_LOG2  = 12,
    parameter int    WAIT_STATES = 0,
    parameter string INIT_FILE   = ""
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_dev_sel,
    input  logic [DEPTH_LOG2-1:0] i_wb_adr,
    input  logic [31:0]           i_wb_dat,
    input  logic [3:0]            i_wb_sel,
    input  logic                  i_wb_we,
    input  logic                  i_wb_stb,
    input  logic                  i_wb_cyc,
    output logic [31:0]           o_wb_dat,
    output logic                  o_wb_ack
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t                state_reg, state_next;
    logic [3:0]            cnt_reg, cnt_next;
    logic [DEPTH_LOG2-1:0] adr_reg;
    logic [31:0]           dat_reg;
    logic [3:0]            sel_reg;
    logic                  we_reg;
    logic [31:0]           rd_reg;

    logic [31:0] mem [DEPTH];

    logic                  req;
    logic                  latch;
    logic                  commit;
    logic [DEPTH_LOG2-1:0] acc_adr;
    logic [31:0]           acc_dat;
    logic [3:0]            acc_sel;
    logic                  acc_we;

    assign req = i_dev_sel & i_wb_cyc & i_wb_stb;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        latch      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    latch = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_next = ACK;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (!i_wb_cyc) begin
                    state_next = IDLE;
                end else if (cnt_reg == 4'd0) begin
                    state_next = ACK;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // With zero wait states the access commits on the same edge that samples
    // the request, so the access fields come straight from the bus in IDLE.
    assign acc_adr = (state_reg == IDLE) ? i_wb_adr : adr_reg;
    assign acc_dat = (state_reg == IDLE) ? i_wb_dat : dat_reg;
    assign acc_sel = (state_reg == IDLE) ? i_wb_sel : sel_reg;
    assign acc_we  = (state_reg == IDLE) ? i_wb_we  : we_reg;
    assign commit  = (state_next == ACK) && (state_reg != ACK);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            adr_reg   <= '0;
            dat_reg   <= 32'd0;
            sel_reg   <= 4'd0;
            we_reg    <= 1'b0;
            rd_reg    <= 32'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (latch) begin
                adr_reg <= i_wb_adr;
                dat_reg <= i_wb_dat;
                sel_reg <= i_wb_sel;
                we_reg  <= i_wb_we;
            end
            if (commit && !acc_we) begin
                rd_reg <= mem[acc_adr];
            end
        end
    end

    // Memory contents survive reset; an in-flight write is dropped by gating on reset.
    always_ff @(posedge i_clk) begin
        if (commit && acc_we && !i_reset) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_sel[i]) begin
                    mem[acc_adr][8*i +: 8] <= acc_dat[8*i +: 8];
                end
            end
        end
    end

    assign o_wb_ack = (state_reg == ACK);
    assign o_wb_dat = rd_reg;

endmodule

// File: tb/tb_wb_tcm.sv
// Self-checking bench for wb_tcm: three instances (no wait states, three wait
// states, 16-word wrap) driven by directed and random transactions.
module tb_wb_tcm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  dev_sel = 3'd0;
    logic [11:0] adr = 12'd0;
    logic [31:0] wdat = 32'd0;
    logic [3:0]  sel = 4'd0;
    logic        we = 1'b0;
    logic        stb = 1'b0;
    logic        cyc = 1'b0;

    logic [2:0]  ack;
    logic [31:0] rdat [3];

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mdl [3][4096];
    logic [31:0] exp_rd [3];

    always #5 clk = ~clk;

    wb_tcm #(.DEPTH_LOG2(12), .WAIT_STATES(0)) dut0 (
        .i_clk(clk), .i_reset(rst), .i_dev_sel(dev_sel[0]), .i_wb_adr(adr),
        .i_wb_dat(wdat), .i_wb_sel(sel), .i_wb_we(we), .i_wb_stb(stb),
        .i_wb_cyc(cyc), .o_wb_dat(rdat[0]), .o_wb_ack(ack[0])
    );

    wb_tcm #(.DEPTH_LOG2(12), .WAIT_STATES(3)) dut1 (
        .i_clk(clk), .i_reset(rst), .i_dev_sel(dev_sel[1]), .i_wb_adr(adr),
        .i_wb_dat(wdat), .i_wb_sel(sel), .i_wb_we(we), .i_wb_stb(stb),
        .i_wb_cyc(cyc), .o_wb_dat(rdat[1]), .o_wb_ack(ack[1])
    );

    wb_tcm #(.DEPTH_LOG2(4), .WAIT_STATES(0)) dut2 (
        .i_clk(clk), .i_reset(rst), .i_dev_sel(dev_sel[2]), .i_wb_adr(adr[3:0]),
        .i_wb_dat(wdat), .i_wb_sel(sel), .i_wb_we(we), .i_wb_stb(stb),
        .i_wb_cyc(cyc), .o_wb_dat(rdat[2]), .o_wb_ack(ack[2])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input int d);
        return (d == 1) ? 4 : 1;
    endfunction

    function automatic int idx_of(input int d, input logic [11:0] a);
        return (d == 2) ? int'(a % 16) : int'(a);
    endfunction

    task automatic drive_req(input int d, input logic w, input logic [11:0] a,
                             input logic [31:0] wd, input logic [3:0] s);
        dev_sel = 3'(1 << d);
        cyc     = 1'b1;
        stb     = 1'b1;
        we      = w;
        adr     = a;
        wdat    = wd;
        sel     = s;
    endtask

    task automatic drop_req();
        dev_sel = 3'd0;
        cyc     = 1'b0;
        stb     = 1'b0;
        we      = 1'b0;
        sel     = 4'd0;
    endtask

    task automatic model_apply(input int d, input logic w, input logic [11:0] a,
                               input logic [31:0] wd, input logic [3:0] s);
        int i;
        i = idx_of(d, a);
        if (w) begin
            for (int n = 0; n < 4; n++)
                if (s[n]) mdl[d][i][8*n +: 8] = wd[8*n +: 8];
        end else begin
            exp_rd[d] = mdl[d][i];
        end
    endtask

    task automatic reset_model();
        for (int d = 0; d < 3; d++) exp_rd[d] = 32'd0;
    endtask

    // One complete access; called at a negedge, returns at a negedge.
    task automatic xfer(input int d, input logic w, input logic [11:0] a,
                        input logic [31:0] wd, input logic [3:0] s);
        int lat;
        lat = lat_of(d);
        drive_req(d, w, a, wd, s);
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq($sformatf("ack d%0d cyc%0d", d, k), 32'(ack[d]), 32'(k == lat));
            if (k == lat) drop_req();
        end
        model_apply(d, w, a, wd, s);
        check_eq($sformatf("rdat d%0d adr %h", d, a), rdat[d], exp_rd[d]);
        @(posedge clk);
        @(negedge clk);
        check_eq($sformatf("ack low d%0d", d), 32'(ack[d]), 32'd0);
        $display("[TB] d%0d %s adr=%h wd=%h sel=%h rd=%h", d, w ? "WR" : "RD", a, wd, s, rdat[d]);
    endtask

    initial begin
        logic [31:0] old;
        reset_model();
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check_eq($sformatf("reset ack d%0d", d), 32'(ack[d]), 32'd0);
            check_eq($sformatf("reset rdat d%0d", d), rdat[d], 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Basic write/read with no wait states.
        xfer(0, 1'b1, 12'd5, 32'hDEADBEEF, 4'hF);
        xfer(0, 1'b0, 12'd5, 32'h0, 4'hF);
        check_eq("basic read", rdat[0], 32'hDEADBEEF);

        // Byte lanes and empty select.
        xfer(0, 1'b1, 12'd7, 32'h11223344, 4'hF);
        xfer(0, 1'b1, 12'd7, 32'hAABBCCDD, 4'b0101);
        xfer(0, 1'b0, 12'd7, 32'h0, 4'h0);
        check_eq("byte lanes", rdat[0], 32'h11BB33DD);
        xfer(0, 1'b1, 12'd7, 32'hFFFFFFFF, 4'h0);
        xfer(0, 1'b0, 12'd7, 32'h0, 4'hF);
        check_eq("sel zero", rdat[0], 32'h11BB33DD);

        // Address wrap on the 16-word instance.
        xfer(2, 1'b1, 12'h013, 32'h12345678, 4'hF);
        xfer(2, 1'b0, 12'h003, 32'h0, 4'hF);
        check_eq("wrap", rdat[2], 32'h12345678);

        // Device not selected: nothing may respond.
        drive_req(0, 1'b0, 12'd5, 32'h0, 4'hF);
        dev_sel = 3'd0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq($sformatf("no sel ack cyc%0d", k), 32'(ack), 32'd0);
        end
        drop_req();
        @(negedge clk);

        // Fill a known working set in every instance.
        for (int a = 0; a < 64; a++) xfer(0, 1'b1, 12'(a), $urandom, 4'hF);
        for (int a = 0; a < 64; a++) xfer(1, 1'b1, 12'(a), $urandom, 4'hF);
        for (int a = 0; a < 16; a++) xfer(2, 1'b1, 12'(a), $urandom, 4'hF);
        mdl[1][11] = ~mdl[1][10];
        xfer(1, 1'b1, 12'd11, mdl[1][11], 4'hF);

        // Held read with wait states: ACK at cycles 4 and 9; address wiggles
        // outside IDLE must be ignored.
        drive_req(1, 1'b0, 12'd10, 32'h0, 4'hF);
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq($sformatf("held ack cyc%0d", k), 32'(ack[1]), 32'(k == 4 || k == 9));
            if (k == 4 || k == 9) check_eq($sformatf("held rdat cyc%0d", k), rdat[1], mdl[1][10]);
            if (k < 4) adr = 12'd11;
            if (k == 4) adr = 12'd10;
            if (k == 9) drop_req();
        end
        exp_rd[1] = mdl[1][10];
        @(posedge clk);
        @(negedge clk);
        check_eq("held ack after", 32'(ack[1]), 32'd0);
        $display("[TB] d1 RD held adr=00a rd=%h", rdat[1]);

        // Abort: drop cyc in the second WAIT cycle of a write.
        old = mdl[1][20];
        drive_req(1, 1'b1, 12'd20, ~old, 4'hF);
        for (int k = 1; k <= 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq($sformatf("abort ack cyc%0d", k), 32'(ack[1]), 32'd0);
        end
        drop_req();
        for (int k = 3; k <= 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq($sformatf("abort ack cyc%0d", k), 32'(ack[1]), 32'd0);
        end
        $display("[TB] d1 WR aborted adr=014");
        xfer(1, 1'b0, 12'd20, 32'h0, 4'hF);
        check_eq("abort mem", rdat[1], old);

        // Reset during WAIT of a write.
        old = mdl[1][21];
        drive_req(1, 1'b1, 12'd21, ~old, 4'hF);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        drop_req();
        #1;
        check_eq("rst wait ack", 32'(ack[1]), 32'd0);
        for (int d = 0; d < 3; d++) check_eq($sformatf("rst rdat d%0d", d), rdat[d], 32'd0);
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        $display("[TB] d1 WR reset adr=015");
        xfer(1, 1'b0, 12'd21, 32'h0, 4'hF);
        check_eq("rst wait mem", rdat[1], old);

        // Reset during the ACK cycle must clear ACK without waiting for a clock.
        drive_req(0, 1'b0, 12'd5, 32'h0, 4'hF);
        @(posedge clk);
        @(negedge clk);
        check_eq("rst ack before", 32'(ack[0]), 32'd1);
        rst = 1'b1;
        drop_req();
        #1;
        check_eq("rst ack async", 32'(ack[0]), 32'd0);
        check_eq("rst ack rdat", rdat[0], 32'd0);
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        $display("[TB] d0 RD reset in ACK");
        @(negedge clk);

        // Random traffic against the reference memories.
        for (int t = 0; t < 150; t++) begin
            int          d;
            logic        w;
            logic [11:0] a;
            d = int'($urandom_range(0, 2));
            w = 1'($urandom_range(0, 1));
            a = (d == 2) ? 12'($urandom) : 12'($urandom_range(0, 63));
            xfer(d, w, a, $urandom, 4'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
